// File: rtl/regdump_pkg.sv
// Shared constants and FSM state encoding for the register dump reader.
package regdump_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        SEND = 2'd2,
        FIN  = 2'd3
    } state_t;

endpackage : regdump_pkg

// File: rtl/regdump_reader_if.sv
// Valid/ready beat stream carrying (register index, register value) pairs.
interface regdump_reader_if #(
    parameter int ADDR_W = regdump_pkg::ADDR_W,
    parameter int DATA_W = regdump_pkg::DATA_W
);

    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] out_idx;
    logic [DATA_W-1:0] out_data;

    modport master (
        output out_valid,
        output out_idx,
        output out_data,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_idx,
        input  out_data,
        output out_ready
    );

endinterface : regdump_reader_if

// File: rtl/regdump_reader.sv
// Walks a register-index range through an external async regfile read port
// and streams each (index, value) pair out, accumulating a 32-bit checksum.
module regdump_reader #(
    parameter int ADDR_W = regdump_pkg::ADDR_W,
    parameter int DATA_W = regdump_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] first_idx,
    input  logic [ADDR_W-1:0] last_idx,
    input  logic              abort,
    output logic [ADDR_W-1:0] rs,
    input  logic [DATA_W-1:0] rdata,
    regdump_reader_if.master  out,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] checksum
);

    import regdump_pkg::*;

    state_t            state;
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W-1:0] last_q;
    logic [ADDR_W-1:0] out_idx_q;
    logic [DATA_W-1:0] out_data_q;

    // Handshake and status flags decode straight from the state register.
    assign busy          = (state != IDLE);
    assign done          = (state == FIN);
    assign out.out_valid = (state == SEND);
    assign out.out_idx   = out_idx_q;
    assign out.out_data  = out_data_q;
    assign rs            = (state == READ) ? idx : '0;

    // NOTE: every register here updates with <= so all reads in this block see
    // the pre-edge values, e.g. checksum adds the beat that was actually shown.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            idx        <= '0;
            last_q     <= '0;
            out_idx_q  <= '0;
            out_data_q <= '0;
            err        <= 1'b0;
            checksum   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        idx      <= first_idx;
                        last_q   <= last_idx;
                        checksum <= '0;
                        err      <= (first_idx > last_idx);
                        state    <= (first_idx > last_idx) ? FIN : READ;
                    end
                end
                READ: begin
                    if (abort) begin
                        state <= IDLE;
                    end else begin
                        out_data_q <= rdata;
                        out_idx_q  <= idx;
                        state      <= SEND;
                    end
                end
                SEND: begin
                    if (abort) begin
                        state <= IDLE;
                    end else if (out.out_ready) begin
                        checksum <= checksum + out_data_q;
                        // Terminating on equality before incrementing keeps idx from wrapping at 31.
                        if (idx == last_q) begin
                            state <= FIN;
                        end else begin
                            idx   <= idx + ADDR_W'(1);
                            state <= READ;
                        end
                    end
                end
                FIN: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule : regdump_reader

// File: tb/tb_regdump_reader.sv
// Directed bench for regdump_reader: vector table of whole dumps plus
// hand-written backpressure, abort and reset sequences.
module tb_regdump_reader;

    import regdump_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [4:0]  first_idx;
    logic [4:0]  last_idx;
    logic        abort;
    logic [4:0]  rs;
    logic [31:0] rdata;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] checksum;

    logic [31:0] regs [32];

    int total = 0;
    int bad   = 0;

    regdump_reader_if bus ();

    regdump_reader dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .first_idx (first_idx),
        .last_idx  (last_idx),
        .abort     (abort),
        .rs        (rs),
        .rdata     (rdata),
        .out       (bus),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .checksum  (checksum)
    );

    always #5 clk = ~clk;

    // Regfile read port model: x0 hardwired to zero.
    assign rdata = (rs == 5'd0) ? 32'd0 : regs[rs];

    typedef struct {
        logic [4:0]  first;
        logic [4:0]  last;
        int          beats;
        logic [31:0] sum;
        logic        err;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] reg_val(input logic [4:0] i);
        return (i == 5'd0) ? 32'd0 : regs[i];
    endfunction

    // Runs one dump with out_ready held high and checks cycle-exact timing.
    task automatic run_dump(input vec_t v);
        int         j;
        logic       exp_valid;
        logic [4:0] exp_idx;
        j         = 0;
        first_idx = v.first;
        last_idx  = v.last;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        first_idx = ~v.first;
        last_idx  = ~v.last;
        for (int c = 1; c <= 2 * v.beats + 1; c++) begin
            exp_valid = (c % 2 == 0) && (c <= 2 * v.beats);
            check("busy", {31'd0, busy}, 32'd1);
            check("out_valid", {31'd0, bus.out_valid}, {31'd0, exp_valid});
            check("done", {31'd0, done}, {31'd0, c == 2 * v.beats + 1});
            if ((c % 2 == 1) && (c < 2 * v.beats)) begin
                exp_idx = v.first + 5'((c - 1) / 2);
                check("rs", {27'd0, rs}, {27'd0, exp_idx});
            end
            if (exp_valid) begin
                exp_idx = v.first + 5'(j);
                check("out_idx", {27'd0, bus.out_idx}, {27'd0, exp_idx});
                check("out_data", bus.out_data, reg_val(exp_idx));
                j++;
            end
            tick();
        end
        check("busy_after", {31'd0, busy}, 32'd0);
        check("done_after", {31'd0, done}, 32'd0);
        check("checksum", checksum, v.sum);
        check("err", {31'd0, err}, {31'd0, v.err});
    endtask

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = 32'h100 + i;
        regs[1]  = 32'h11;
        regs[2]  = 32'h22;
        regs[3]  = 32'h33;
        regs[30] = 32'hFFFF_FFFF;
        regs[31] = 32'h0000_0002;

        vecs[0] = '{first: 5'd1,  last: 5'd3,  beats: 3, sum: 32'h66,  err: 1'b0};
        vecs[1] = '{first: 5'd0,  last: 5'd0,  beats: 1, sum: 32'h0,   err: 1'b0};
        vecs[2] = '{first: 5'd5,  last: 5'd2,  beats: 0, sum: 32'h0,   err: 1'b1};
        vecs[3] = '{first: 5'd30, last: 5'd31, beats: 2, sum: 32'h1,   err: 1'b0};
        vecs[4] = '{first: 5'd4,  last: 5'd4,  beats: 1, sum: 32'h104, err: 1'b0};
        vecs[5] = '{first: 5'd31, last: 5'd31, beats: 1, sum: 32'h2,   err: 1'b0};

        rst           = 1'b1;
        start         = 1'b0;
        abort         = 1'b0;
        first_idx     = 5'd0;
        last_idx      = 5'd0;
        bus.out_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_checksum", checksum, 32'd0);
        check("rst_out_idx", {27'd0, bus.out_idx}, 32'd0);
        check("rst_out_data", bus.out_data, 32'd0);
        check("rst_rs", {27'd0, rs}, 32'd0);

        for (int v = 0; v < 6; v++) run_dump(vecs[v]);

        // Backpressure: hold the first beat for 4 cycles, poke start meanwhile.
        bus.out_ready = 1'b0;
        first_idx = 5'd1;
        last_idx  = 5'd2;
        start     = 1'b1;
        tick();
        start = 1'b0;
        tick();
        for (int k = 0; k < 4; k++) begin
            check("bp_valid", {31'd0, bus.out_valid}, 32'd1);
            check("bp_idx", {27'd0, bus.out_idx}, 32'd1);
            check("bp_data", bus.out_data, 32'h11);
            first_idx = 5'd7;
            last_idx  = 5'd9;
            start     = (k == 1);
            tick();
        end
        start = 1'b0;
        bus.out_ready = 1'b1;
        check("bp_hold_valid", {31'd0, bus.out_valid}, 32'd1);
        check("bp_hold_idx", {27'd0, bus.out_idx}, 32'd1);
        tick();
        check("bp_read_gap", {31'd0, bus.out_valid}, 32'd0);
        tick();
        check("bp_beat2_idx", {27'd0, bus.out_idx}, 32'd2);
        check("bp_beat2_data", bus.out_data, 32'h22);
        tick();
        check("bp_done", {31'd0, done}, 32'd1);
        check("bp_checksum", checksum, 32'h33);
        tick();
        check("bp_idle", {31'd0, busy}, 32'd0);

        // Abort during the second SEND, with the beat also being accepted.
        first_idx = 5'd1;
        last_idx  = 5'd3;
        start     = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        check("ab_valid", {31'd0, bus.out_valid}, 32'd1);
        check("ab_idx", {27'd0, bus.out_idx}, 32'd2);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("ab_checksum", checksum, 32'h11);
        for (int k = 0; k < 3; k++) begin
            check("ab_busy", {31'd0, busy}, 32'd0);
            check("ab_valid_after", {31'd0, bus.out_valid}, 32'd0);
            check("ab_no_done", {31'd0, done}, 32'd0);
            tick();
        end

        // Reset while in READ.
        first_idx = 5'd2;
        last_idx  = 5'd3;
        start     = 1'b1;
        tick();
        start = 1'b0;
        check("rr_rs", {27'd0, rs}, 32'd2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rr_busy", {31'd0, busy}, 32'd0);
        check("rr_done", {31'd0, done}, 32'd0);
        check("rr_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rr_rs0", {27'd0, rs}, 32'd0);
        check("rr_checksum", checksum, 32'd0);
        check("rr_out_idx", {27'd0, bus.out_idx}, 32'd0);
        check("rr_out_data", bus.out_data, 32'd0);
        check("rr_err", {31'd0, err}, 32'd0);
        run_dump(vecs[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_regdump_reader
